// File: rtl/immgen_pipe_if.sv
// Decode-stage handshake bundle: instruction/pc in, decoded immediate and target out.
// Both sides use valid/ready; master is the producer of in_* and consumer of out_*.
// The block under test connects through the slave modport.
interface immgen_pipe_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_target;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_target
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_target
    );
endinterface

// File: rtl/immgen_pipe.sv
// Immediate generator: decodes RV I/S/B/U/J immediates, flags illegal opcodes, adds pc.
// Latency: one cycle from accept to out_* when empty (or when draining in the same cycle).
// Backpressure: two-entry skid (main + skid); in_ready comes from registered state only.
module immgen_pipe #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    immgen_pipe_if.slave  bus
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_OPIMM    = 5'b00100;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_OPIMM32  = 5'b00110;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_JAL      = 5'b11011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    entry_t      m_q;
    entry_t      s_q;
    entry_t      dec;
    logic [31:0] inst;
    logic [31:0] imm32;
    logic        accept;
    logic        drain;
    logic        load_m_in;
    logic        load_m_skid;
    logic        load_s;

    assign inst = bus.in_inst;

    // All formats fit in 32 bits; one signed widening handles XLEN=32 and 64 alike.
    always_comb begin
        imm32       = '0;
        dec         = '0;
        dec.pc      = bus.in_pc;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:2])
                OP_LOAD, OP_OPIMM, OP_JALR: begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{inst[31]}}, inst[31:20]};
                end
                OP_OPIMM32: begin
                    if (XLEN == 64) begin
                        dec.fmt = FMT_I;
                        imm32   = {{20{inst[31]}}, inst[31:20]};
                    end
                end
                OP_STORE: begin
                    dec.fmt = FMT_S;
                    imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                end
                OP_BRANCH: begin
                    dec.fmt = FMT_B;
                    imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    dec.fmt = FMT_U;
                    imm32   = {inst[31:12], 12'b0};
                end
                OP_JAL: begin
                    dec.fmt = FMT_J;
                    imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                default: ;
            endcase
        end
        if (dec.fmt != FMT_NONE) begin
            dec.illegal = 1'b0;
            dec.imm     = XLEN'($signed(imm32));
        end
    end

    assign accept = bus.in_valid && (state_q != FULL);
    assign drain  = bus.out_ready && (state_q != EMPTY);

    always_comb begin
        state_d     = state_q;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    load_s  = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d     = ONE;
                    load_m_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load_m_in) begin
                m_q <= dec;
            end else if (load_m_skid) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= dec;
            end
        end
    end

    assign bus.in_ready    = (state_q != FULL);
    assign bus.out_valid   = (state_q != EMPTY);
    assign bus.out_imm     = m_q.imm;
    assign bus.out_fmt     = m_q.fmt;
    assign bus.out_illegal = m_q.illegal;
    assign bus.out_pc      = m_q.pc;
    // Wraps modulo 2^XLEN by construction.
    assign bus.out_target  = m_q.pc + m_q.imm;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: queue-based reference model plus directed literal cases,
// on an XLEN=64 instance (main) and an XLEN=32 instance (width-specific cases).
module tb_immgen_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    immgen_pipe_if #(.XLEN(64)) bus ();
    immgen_pipe_if #(.XLEN(32)) bus32 ();

    immgen_pipe #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    immgen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int checks = 0;
    int errors = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;
    ent_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_fmt(input logic [31:0] inst, input int xlen);
        if (inst[1:0] != 2'b11) return 3'd0;
        case (inst[6:2])
            5'b00000, 5'b00100, 5'b11001: return 3'd1;
            5'b00110:                     return (xlen == 64) ? 3'd1 : 3'd0;
            5'b01000:                     return 3'd2;
            5'b11000:                     return 3'd3;
            5'b01101, 5'b00101:           return 3'd4;
            5'b11011:                     return 3'd5;
            default:                      return 3'd0;
        endcase
    endfunction

    // Immediate as a signed integer, then reduced to xlen bits (zero-padded to 64).
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input int xlen);
        longint s;
        longint v;
        s = longint'($signed(inst));
        case (ref_fmt(inst, xlen))
            3'd1: v = s >>> 20;
            3'd2: v = (s >>> 25) * 32 + longint'(inst[11:7]);
            3'd3: v = (s >>> 31) * 4096 + longint'(inst[7]) * 2048
                      + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
            3'd4: v = s - longint'(inst[11:0]);
            3'd5: v = (s >>> 31) * 1048576 + longint'(inst[19:12]) * 4096
                      + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    function automatic logic [31:0] rand_inst(input bit legal_only);
        logic [31:0] w;
        logic [4:0]  op;
        w = $urandom;
        case ($urandom_range(0, 8))
            0: op = 5'b00000;
            1: op = 5'b00100;
            2: op = 5'b11001;
            3: op = 5'b00110;
            4: op = 5'b01000;
            5: op = 5'b11000;
            6: op = 5'b01101;
            7: op = 5'b00101;
            default: op = 5'b11011;
        endcase
        if (legal_only || $urandom_range(0, 5) != 0) begin
            w[6:2] = op;
            w[1:0] = 2'b11;
        end
        return w;
    endfunction

    // Scoreboard: occupancy predicts in_ready/out_valid, head predicts out_* contents.
    always @(negedge clk) begin : compare
        ent_t        e;
        logic [63:0] ei;
        if (rst) begin
            q.delete();
        end else begin
            chk("in_ready", {63'b0, bus.in_ready}, {63'b0, q.size() < 2});
            chk("out_valid", {63'b0, bus.out_valid}, {63'b0, q.size() > 0});
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                e  = q.pop_front();
                ei = ref_imm(e.inst, 64);
                chk("out_fmt", {61'b0, bus.out_fmt}, {61'b0, ref_fmt(e.inst, 64)});
                chk("out_imm", bus.out_imm, ei);
                chk("out_illegal", {63'b0, bus.out_illegal}, {63'b0, ref_fmt(e.inst, 64) == 3'd0});
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_target", bus.out_target, e.pc + ei);
                out_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back('{bus.in_inst, bus.in_pc});
                in_cnt++;
            end
        end
    end

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send32(input string name, input logic [31:0] inst, input logic [2:0] fmt,
                          input logic [31:0] imm, input logic ill);
        bus32.in_valid = 1'b1;
        bus32.in_inst  = inst;
        bus32.in_pc    = 32'h0000_4000;
        @(negedge clk);
        chk({name, "_in_ready"}, {63'b0, bus32.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, {63'b0, bus32.out_valid}, 64'd1);
        chk({name, "_fmt"}, {61'b0, bus32.out_fmt}, {61'b0, fmt});
        chk({name, "_imm"}, {32'b0, bus32.out_imm}, {32'b0, imm});
        chk({name, "_illegal"}, {63'b0, bus32.out_illegal}, {63'b0, ill});
        chk({name, "_target"}, {32'b0, bus32.out_target}, {32'b0, 32'h0000_4000 + imm});
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  base;
        bit  acc;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_inst = '0; bus32.in_pc = '0; bus32.out_ready = 1'b1;

        // Hand-computed anchors for the model itself.
        chk("model_addi", ref_imm(32'hFFF00093, 64), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_sw", ref_imm(32'hFE112E23, 64), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_beq", ref_imm(32'hFE000FE3, 64), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("model_lui32", ref_imm(32'h800000B7, 32), 64'h0000_0000_8000_0000);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("rst_out_imm", bus.out_imm, 64'd0);
        chk("rst_out_target", bus.out_target, 64'd0);
        chk("rst_out_fmt", {61'b0, bus.out_fmt}, 64'd0);
        rst = 1'b0;

        // Directed decode cases with literal expectations.
        bus.out_ready = 1'b1;
        send(32'hFFF00093, 64'h1000);
        @(negedge clk);
        chk("addi_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("addi_fmt", {61'b0, bus.out_fmt}, 64'd1);
        chk("addi_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_target", bus.out_target, 64'h0FFF);
        chk("addi_illegal", {63'b0, bus.out_illegal}, 64'd0);
        @(posedge clk); #1;
        send(32'hFE112E23, 64'h2000);
        @(negedge clk);
        chk("sw_fmt", {61'b0, bus.out_fmt}, 64'd2);
        chk("sw_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;
        send(32'hFE000FE3, 64'h100);
        @(negedge clk);
        chk("beq_fmt", {61'b0, bus.out_fmt}, 64'd3);
        chk("beq_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("beq_target", bus.out_target, 64'h00FE);
        @(posedge clk); #1;
        send(32'h800000B7, 64'h0);
        @(negedge clk);
        chk("lui64_imm", bus.out_imm, 64'hFFFF_FFFF_8000_0000);
        @(posedge clk); #1;
        send(32'h00000013 | 32'h3, 64'h10);  // opcode bits fine, checks via model only
        send(32'h00000000, 64'h20);          // inst[1:0]=00 -> illegal, still flows
        @(negedge clk);
        chk("illegal_flag", {63'b0, bus.out_illegal}, 64'd1);
        chk("illegal_imm", bus.out_imm, 64'd0);
        @(posedge clk); #1;

        // XLEN=32 instance.
        send32("lui32", 32'h800000B7, 3'd4, 32'h8000_0000, 1'b0);
        send32("opimm32_x32", 32'h0010009B, 3'd0, 32'h0, 1'b1);
        send32("addi32", 32'hFFF00093, 3'd1, 32'hFFFF_FFFF, 1'b0);

        // Back-pressure: two accepted, third held until drain starts.
        bus.out_ready = 1'b0;
        base = out_cnt;
        send(32'h00100093, 64'hA000);
        send(32'h00200113, 64'hA004);
        bus.in_valid = 1'b1; bus.in_inst = 32'h00300193; bus.in_pc = 64'hA008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'b0, bus.in_ready}, 64'd0);
            chk("bp_pc_stable", bus.out_pc, 64'hA000);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send(32'h00300193, 64'hA008);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", out_cnt - base, 3);

        // Full-rate stream of 16 legal instructions.
        base = out_cnt;
        for (int i = 0; i < 16; i++) send(rand_inst(1'b1), {$urandom, $urandom});
        repeat (2) @(posedge clk);
        #1;
        chk("stream16_count", out_cnt - base, 16);

        // Randomized valid/ready traffic; upstream holds while stalled.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_inst  = rand_inst(1'b0);
                bus.in_pc    = {$urandom, $urandom};
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("random_in_eq_out", out_cnt, in_cnt);

        // Async reset while FULL.
        bus.out_ready = 1'b0;
        send(32'h00500293, 64'hB000);
        send(32'h00600313, 64'hB004);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("arst_in_ready", {63'b0, bus.in_ready}, 64'd1);
        chk("arst_out_pc", bus.out_pc, 64'd0);
        chk("arst_out_target", bus.out_target, 64'd0);
        chk("arst_out_illegal", {63'b0, bus.out_illegal}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(32'h00700393, 64'hC000);
        @(negedge clk);
        chk("post_rst_pc", bus.out_pc, 64'hC000);
        chk("post_rst_imm", bus.out_imm, 64'd7);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_no_stale", {63'b0, bus.out_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
